ga_run_controller: RTL

Sequences one morphologic GA run: holds the GA in reset, releases it, and counts generations from its `cycle` output. It stops on zero error or a generation limit, then hands `{generation, bestIndividual}` to the serial TX package with a busy handshake. It sits between the GA core and the serial packager in the debug top level.

---
 rtl/ga_ctrl_pkg.sv | 8 +
 rtl/ga_run_controller_if.sv | 24 ++
 rtl/ga_ctrl_edge_sync.sv | 26 ++
 rtl/ga_run_controller.sv | 128 ++++++++++++
 4 files changed

// File: rtl/ga_ctrl_pkg.sv
// ga_ctrl_pkg: shared state encodings and report-word defaults for the GA run controller
package ga_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, HOLD, RUN, LATCH, SEND, WAIT, DONE} state_e;
  typedef enum logic [1:0] {P_IDLE, P_SEND, P_WAIT} psend_e;
  // Report word is {generation, bestIndividual}: generation occupies the MSBs
  localparam int DefaultGenWidth = 32;
  localparam int DefaultIndividualWidth = 32;
endpackage

// File: rtl/ga_run_controller_if.sv
// ga_run_controller_if: GA-core and serial-packager signals seen by the run controller
interface ga_run_controller_if
  import ga_ctrl_pkg::*;
#(
  parameter int IndividualWidth = DefaultIndividualWidth,
  parameter int ErrorWidth = 5,
  parameter int GenWidth = DefaultGenWidth
);
  logic cycle;
  logic [ErrorWidth-1:0] bestError;
  logic [IndividualWidth-1:0] bestIndividual;
  logic gaRst;
  logic txBusy;
  logic serialCe;
  logic [GenWidth+IndividualWidth-1:0] reportData;
  modport master (
    input cycle, bestError, bestIndividual, txBusy,
    output gaRst, serialCe, reportData
  );
  modport slave (
    output cycle, bestError, bestIndividual, txBusy,
    input gaRst, serialCe, reportData
  );
endinterface

// File: rtl/ga_ctrl_edge_sync.sv
// ga_ctrl_edge_sync: 2-flop synchronizer plus registered rising-edge detector (3-cycle latency)
module ga_ctrl_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic tick
);
  logic [2:0] sync_q, sync_d;
  logic tick_q, tick_d;
  // Shift the async level in; bit 2 is the previous synchronized value for edge detection
  always_comb begin
    sync_d = {sync_q[1:0], din};
    tick_d = sync_q[1] & ~sync_q[2];
  end
  // Synchronizer and tick registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      tick_q <= tick_d;
    end
  end
  assign tick = tick_q;
endmodule

// File: rtl/ga_run_controller.sv
// ga_run_controller: sequences one GA run and reports {generation, bestIndividual}; GA_CTRL_PERIODIC_REPORT_EN adds periodic reports
module ga_run_controller
  import ga_ctrl_pkg::*;
#(
  parameter int IndividualWidth = DefaultIndividualWidth,
  parameter int ErrorWidth = 5,
  parameter int GenWidth = DefaultGenWidth,
  parameter int MaxGenerations = 2**20,
  parameter int GaResetCycles = 4
`ifdef GA_CTRL_PERIODIC_REPORT_EN
  ,
  parameter int ReportInterval = 1024
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  ga_run_controller_if.master bus,
  output logic [GenWidth-1:0] generation,
  output logic running,
  output logic finish,
  output logic timeout
);
  localparam int RW = GenWidth + IndividualWidth;
  localparam int HoldW = $clog2(GaResetCycles + 2);
  state_e state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [GenWidth-1:0] gen_q, gen_d, gen_inc;
  logic to_q, to_d;
  logic [RW-1:0] rep_q, rep_d;
  logic tick, zero_err, at_limit, stop, p_idle, p_ce;

  ga_ctrl_edge_sync u_sync (.clk(clk), .rst(rst), .din(bus.cycle), .tick(tick));

  assign gen_inc = gen_q + 1'b1;
  assign zero_err = bus.bestError == '0;
  assign at_limit = (MaxGenerations != 0) && (gen_inc == GenWidth'(MaxGenerations));
  assign stop = abort || (tick && (zero_err || at_limit));

`ifdef GA_CTRL_PERIODIC_REPORT_EN
  psend_e p_q, p_d;
  logic per_go;
  assign per_go = state_q == RUN && tick && !stop && p_idle && (gen_inc % GenWidth'(ReportInterval)) == '0;
  assign p_idle = p_q == P_IDLE;
  assign p_ce = p_q == P_SEND;
  // Periodic send/wait handshake runs beside RUN so counting never pauses
  always_comb begin
    p_d = per_go ? P_SEND :
          (p_q == P_SEND && bus.txBusy) ? P_WAIT :
          (p_q == P_WAIT && !bus.txBusy) ? P_IDLE : p_q;
  end
  // Periodic handshake state register
  always_ff @(posedge clk) begin
    p_q <= rst ? P_IDLE : p_d;
  end
`else
  assign p_idle = 1'b1;
  assign p_ce = 1'b0;
`endif

  // Run FSM: next state, hold/generation counters and report capture
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    gen_d = gen_q;
    to_d = to_q;
    rep_d = rep_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = HOLD;
          hold_d = HoldW'(GaResetCycles);
          gen_d = '0;
          to_d = 1'b0;
        end
      end
      HOLD: begin
        hold_d = hold_q - 1'b1;
        state_d = hold_q <= HoldW'(1) ? RUN : HOLD;
      end
      RUN: begin
        gen_d = tick ? gen_inc : gen_q;
        if (stop) begin
          state_d = LATCH;
          to_d = tick && at_limit && !zero_err && !abort;
        end
`ifdef GA_CTRL_PERIODIC_REPORT_EN
        if (per_go) rep_d = {gen_inc, bus.bestIndividual};
`endif
      end
      LATCH: begin
        if (p_idle) begin
          rep_d = {gen_q, bus.bestIndividual};
          state_d = SEND;
        end
      end
      SEND: state_d = bus.txBusy ? WAIT : SEND;
      WAIT: state_d = bus.txBusy ? WAIT : DONE;
      default: state_d = IDLE;
    endcase
  end

  // Run FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q <= '0;
      gen_q <= '0;
      to_q <= 1'b0;
      rep_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      gen_q <= gen_d;
      to_q <= to_d;
      rep_q <= rep_d;
    end
  end

  assign bus.gaRst = !(state_q inside {RUN, LATCH, SEND, WAIT});
  assign bus.serialCe = state_q == SEND || p_ce;
  assign bus.reportData = rep_q;
  assign generation = gen_q;
  assign running = state_q == RUN;
  assign finish = state_q == DONE;
  assign timeout = to_q && state_q == DONE;
endmodule
